pc_predict: RTL

- Program counter for the fetch stage with a direct-mapped branch target buffer (BTB) and a 2-bit saturating predictor per entry.
- Parametrised in address width, BTB depth and reset vector.
- Drives the instruction address and the prediction tag to the fetch/decode latch.
- Later stages correct mispredicts through a redirect port and train the BTB through an update port.

---
 rtl/btb_pkg.sv | 21 ++
 rtl/pc_predict_if.sv | 34 +++
 rtl/btb_dm.sv | 91 +++++++++
 rtl/pc_predict.sv | 73 +++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared BTB definitions: 2-bit predictor counter type, its named states and
// saturating step helpers. The entry struct itself depends on PC_W and the
// BTB depth, so it is declared inside btb_dm where those parameters are known.
package btb_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t STRONG_NT = 2'b00;
    localparam ctr_t WEAK_NT   = 2'b01;
    localparam ctr_t WEAK_T    = 2'b10;
    localparam ctr_t STRONG_T  = 2'b11;

    function automatic ctr_t ctr_inc(input ctr_t c);
        return (c == STRONG_T) ? c : c + 2'b01;
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t c);
        return (c == STRONG_NT) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/pc_predict_if.sv
// Bundle of the pc_predict signals.
//   pc : view of the predictor block (drives imemaddr/npc/prediction).
//   tb : view of the environment (drives control, redirect and training).
interface pc_predict_if #(
    parameter int unsigned PC_W = 32
) (
    input logic CLK
);
    logic            nRST;
    logic            ihit;
    logic            stall;
    logic            redirect;
    logic [PC_W-1:0] redirect_addr;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic [PC_W-1:0] upd_target;
    logic            upd_taken;
    logic [PC_W-1:0] imemaddr;
    logic [PC_W-1:0] npc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;

    modport pc (
        input  CLK, nRST, ihit, stall, redirect, redirect_addr,
        input  upd_valid, upd_pc, upd_target, upd_taken,
        output imemaddr, npc, pred_taken, pred_target
    );

    modport tb (
        input  CLK, imemaddr, npc, pred_taken, pred_target,
        output nRST, ihit, stall, redirect, redirect_addr,
        output upd_valid, upd_pc, upd_target, upd_taken
    );
endinterface

// File: rtl/btb_dm.sv
// Direct-mapped branch target buffer with a 2-bit saturating counter per entry.
// Ports:
//   CLK, nRST          clock / async active-low reset
//   lookup_pc          fetch address to predict for (combinational lookup)
//   hit_taken          entry hits and its counter says taken
//   hit_target         stored target of the indexed entry
//   upd_valid/pc/target/taken  training strobe from branch resolution
module btb_dm
    import btb_pkg::*;
#(
    parameter int unsigned PC_W        = 32,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned BTB_IDX_W   = $clog2(BTB_ENTRIES)
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            hit_taken,
    output logic [PC_W-1:0] hit_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_taken
);
    localparam int unsigned TAG_W = PC_W - BTB_IDX_W - 2;

    typedef struct packed {
        logic            valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0] target;
        ctr_t            ctr;
    } btb_entry_t;

    localparam btb_entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};

    btb_entry_t [BTB_ENTRIES-1:0] entries_q;

    logic [BTB_IDX_W-1:0] lookup_idx, upd_idx;
    logic [TAG_W-1:0]     lookup_tag, upd_tag;
    btb_entry_t           rd_entry, upd_old, upd_entry;
    logic                 upd_hit, upd_we;

    // Byte-offset bits never take part in indexing or tagging.
    logic unused_offset;
    assign unused_offset = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lookup_idx = lookup_pc[BTB_IDX_W+1:2];
    assign lookup_tag = lookup_pc[PC_W-1:BTB_IDX_W+2];
    assign upd_idx    = upd_pc[BTB_IDX_W+1:2];
    assign upd_tag    = upd_pc[PC_W-1:BTB_IDX_W+2];

    // Lookup reads the registered array, so a same-cycle update is not seen yet.
    assign rd_entry   = entries_q[lookup_idx];
    assign hit_taken  = rd_entry.valid && (rd_entry.tag == lookup_tag) && rd_entry.ctr[1];
    assign hit_target = rd_entry.target;

    assign upd_old = entries_q[upd_idx];
    assign upd_hit = upd_old.valid && (upd_old.tag == upd_tag);

    always_comb begin
        upd_we    = 1'b0;
        upd_entry = upd_old;
        if (upd_valid) begin
            if (upd_hit) begin
                upd_we = 1'b1;
                if (upd_taken) begin
                    upd_entry.ctr    = ctr_inc(upd_old.ctr);
                    upd_entry.target = upd_target;
                end else begin
                    upd_entry.ctr = ctr_dec(upd_old.ctr);
                end
            end else if (upd_taken) begin
                // Allocation evicts whatever aliases to this index.
                upd_we           = 1'b1;
                upd_entry.valid  = 1'b1;
                upd_entry.tag    = upd_tag;
                upd_entry.target = upd_target;
                upd_entry.ctr    = WEAK_T;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            entries_q <= {BTB_ENTRIES{RESET_ENTRY}};
        end else if (upd_we) begin
            entries_q[upd_idx] <= upd_entry;
        end
    end

endmodule

// File: rtl/pc_predict.sv
// Fetch-stage program counter with BTB-based next-PC prediction.
// Ports:
//   CLK, nRST                 clock / async active-low reset
//   ihit, stall               advance enable (ihit) and hazard hold (stall)
//   redirect, redirect_addr   correction from a later stage; highest priority
//   upd_*                     BTB training from branch resolution
//   imemaddr                  current fetch address (pc register)
//   npc                       pc + 4 (wraps)
//   pred_taken, pred_target   prediction for the current fetch
module pc_predict #(
    parameter logic [31:0] PC_INIT     = 32'd0,
    parameter int unsigned PC_W        = 32,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned BTB_IDX_W   = $clog2(BTB_ENTRIES)
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            ihit,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_addr,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_taken,
    output logic [PC_W-1:0] imemaddr,
    output logic [PC_W-1:0] npc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target
);
    localparam logic [PC_W-1:0] PC_RST = PC_W'(PC_INIT);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] btb_target;

    btb_dm #(
        .PC_W        (PC_W),
        .BTB_ENTRIES (BTB_ENTRIES),
        .BTB_IDX_W   (BTB_IDX_W)
    ) u_btb (
        .CLK        (CLK),
        .nRST       (nRST),
        .lookup_pc  (pc_q),
        .hit_taken  (pred_taken),
        .hit_target (btb_target),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken)
    );

    assign imemaddr    = pc_q;
    assign npc         = pc_q + PC_W'(4);
    assign pred_target = pred_taken ? btb_target : npc;

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_addr;
        end else if (ihit && !stall) begin
            pc_d = pred_target;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q <= PC_RST;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule
